// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_pkg
// Description : Shared types and helpers for the fifo_core slice.
//               PTR_W is the width of the wr_ptr, rd_ptr and cnt ports; it is
//               fixed at 8 bits so the protocol checker can bind without
//               knowing DEPTH.
// Contents    : PTR_W    - pointer/count width
//               ptr_t    - pointer/count type
//               next_ptr - increment with wrap at depth-1
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

  localparam int PTR_W = 8;

  typedef logic [PTR_W-1:0] ptr_t;

  // Advance a slot index, wrapping depth-1 back to slot 0. This is not a
  // plain modulo-2^PTR_W increment, so pointers never leave 0..depth-1.
  function automatic ptr_t next_ptr(input ptr_t ptr, input ptr_t depth);
    ptr_t w_last;
    w_last = depth - ptr_t'(1);
    return (ptr == w_last) ? '0 : ptr + ptr_t'(1);
  endfunction

endpackage : fifo_pkg
`default_nettype wire

// File: rtl/fifo_mem.sv
`default_nettype none
// ============================================================================
// Module      : fifo_mem
// Description : DEPTH x WIDTH storage array for fifo_core. It has one
//               synchronous write port and one synchronous read port with a
//               registered output. The array itself is never reset; only the
//               read data register is.
// Ports       : clk   - system clock
//               rst   - asynchronous active-low reset (clears rdata only)
//               we    - write enable
//               waddr - write slot
//               wdata - write data
//               re    - read enable; rdata loads mem[raddr]
//               raddr - read slot
//               rdata - registered read data, held when re is low
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_mem #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  // No reset on the array, so it can map onto plain register files or RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  // The read register sees the array contents from before this edge's
  // write. A write and a read to the same slot therefore never bypass.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rdata <= '0;
    end else if (re) begin
      r_rdata <= r_mem[raddr];
    end
  end

  assign rdata = r_rdata;

endmodule : fifo_mem
`default_nettype wire

// File: rtl/fifo_core.sv
`default_nettype none
// ============================================================================
// Module      : fifo_core
// Description : Single-clock FIFO between a byte producer and a byte
//               consumer. It exposes status and pointer state directly so
//               the FIFO protocol checker can bind to it with no glue logic.
// Ports       : clk        - system clock, rising edge
//               rst        - asynchronous active-low reset
//               fifo_write - write request, data_in is taken when accepted
//               fifo_read  - read request
//               data_in    - write data
//               data_out   - registered read data (one-cycle latency)
//               fifo_full  - cnt == DEPTH
//               fifo_empty - cnt == 0
//               wr_ptr     - next write slot, 0..DEPTH-1
//               rd_ptr     - next read slot, 0..DEPTH-1
//               cnt        - occupancy, 0..DEPTH
//               overflow   - sticky, a write was rejected
//               underflow  - sticky, a read was rejected
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_core
  import fifo_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fifo_write,
  input  logic             fifo_read,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             fifo_full,
  output logic             fifo_empty,
  output logic [PTR_W-1:0] wr_ptr,
  output logic [PTR_W-1:0] rd_ptr,
  output logic [PTR_W-1:0] cnt,
  output logic             overflow,
  output logic             underflow
);

  localparam int   c_AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam ptr_t c_DEPTH = ptr_t'(DEPTH);

  ptr_t r_wr_ptr;
  ptr_t r_rd_ptr;
  ptr_t r_cnt;
  logic r_overflow;
  logic r_underflow;

  logic w_full;
  logic w_empty;
  logic w_wr_ok;
  logic w_rd_ok;

  // The flags are decoded from the count register only, so they change in
  // the same cycle as cnt and have no path from the request inputs.
  assign w_full  = (r_cnt == c_DEPTH);
  assign w_empty = (r_cnt == '0);

  // When the FIFO is full, a simultaneous read frees the slot being written.
  // A read is only refused when empty, so fifo_read on a full FIFO is always
  // accepted.
  assign w_wr_ok = fifo_write && (!w_full || fifo_read);
  assign w_rd_ok = fifo_read && !w_empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_cnt       <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_ok) begin
        r_wr_ptr <= next_ptr(r_wr_ptr, c_DEPTH);
      end
      if (w_rd_ok) begin
        r_rd_ptr <= next_ptr(r_rd_ptr, c_DEPTH);
      end

      if (w_wr_ok && !w_rd_ok) begin
        r_cnt <= r_cnt + ptr_t'(1);
      end else if (w_rd_ok && !w_wr_ok) begin
        r_cnt <= r_cnt - ptr_t'(1);
      end

      if (fifo_write && !w_wr_ok) begin
        r_overflow <= 1'b1;
      end
      if (fifo_read && !w_rd_ok) begin
        r_underflow <= 1'b1;
      end
    end
  end

  fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH),
    .AW    (c_AW)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (w_wr_ok),
    .waddr (r_wr_ptr[c_AW-1:0]),
    .wdata (data_in),
    .re    (w_rd_ok),
    .raddr (r_rd_ptr[c_AW-1:0]),
    .rdata (data_out)
  );

  assign fifo_full  = w_full;
  assign fifo_empty = w_empty;
  assign wr_ptr     = r_wr_ptr;
  assign rd_ptr     = r_rd_ptr;
  assign cnt        = r_cnt;
  assign overflow   = r_overflow;
  assign underflow  = r_underflow;

endmodule : fifo_core
`default_nettype wire

// File: tb/tb_fifo_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_core
// Description : Self-checking bench for fifo_core (DEPTH=16, WIDTH=8).
//               Each stimulus cycle updates a queue-based reference FIFO
//               and pushes that cycle's expected DUT state to a scoreboard.
//               A monitor pops one entry after every rising edge and
//               compares it with the DUT outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_core;

  localparam int DEPTH = 16;
  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             fifo_write = 1'b0;
  logic             fifo_read = 1'b0;
  logic [WIDTH-1:0] data_in = '0;
  logic [WIDTH-1:0] data_out;
  logic             fifo_full;
  logic             fifo_empty;
  logic [7:0]       wr_ptr;
  logic [7:0]       rd_ptr;
  logic [7:0]       cnt;
  logic             overflow;
  logic             underflow;

  fifo_core #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_write (fifo_write),
    .fifo_read  (fifo_read),
    .data_in    (data_in),
    .data_out   (data_out),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .wr_ptr     (wr_ptr),
    .rd_ptr     (rd_ptr),
    .cnt        (cnt),
    .overflow   (overflow),
    .underflow  (underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] dout;
    logic [7:0] cnt;
    logic [7:0] wp;
    logic [7:0] rp;
    logic       full;
    logic       empty;
    logic       ovf;
    logic       udf;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: a plain queue of stored bytes plus running totals.
  logic [7:0] model_q[$];
  int         wr_total;
  int         rd_total;
  logic [7:0] m_dout;
  logic       m_ovf;
  logic       m_udf;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, expv);
    end
  endtask

  // One bench cycle: drive inputs at the falling edge and advance the model.
  task automatic step(input logic rst_v, input logic w, input logic r, input logic [7:0] d);
    exp_t e;
    bit wok;
    bit rok;
    @(negedge clk);
    rst        = rst_v;
    fifo_write = w;
    fifo_read  = r;
    data_in    = d;
    if (!rst_v) begin
      model_q.delete();
      wr_total = 0;
      rd_total = 0;
      m_dout   = 8'h00;
      m_ovf    = 1'b0;
      m_udf    = 1'b0;
    end else begin
      wok = w && ((model_q.size() < DEPTH) || r);
      rok = r && (model_q.size() > 0);
      if (w && !wok) m_ovf = 1'b1;
      if (r && !rok) m_udf = 1'b1;
      if (rok) begin
        m_dout = model_q.pop_front();
        rd_total++;
      end
      if (wok) begin
        model_q.push_back(d);
        wr_total++;
      end
    end
    e.dout  = m_dout;
    e.cnt   = 8'(model_q.size());
    e.wp    = 8'(wr_total % DEPTH);
    e.rp    = 8'(rd_total % DEPTH);
    e.full  = (model_q.size() == DEPTH);
    e.empty = (model_q.size() == 0);
    e.ovf   = m_ovf;
    e.udf   = m_udf;
    exp_q.push_back(e);
  endtask

  // Monitor: one scoreboard entry per rising edge, sampled just after it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("data_out",   32'(data_out),   32'(e.dout));
        chk("cnt",        32'(cnt),        32'(e.cnt));
        chk("wr_ptr",     32'(wr_ptr),     32'(e.wp));
        chk("rd_ptr",     32'(rd_ptr),     32'(e.rp));
        chk("fifo_full",  32'(fifo_full),  32'(e.full));
        chk("fifo_empty", 32'(fifo_empty), 32'(e.empty));
        chk("overflow",   32'(overflow),   32'(e.ovf));
        chk("underflow",  32'(underflow),  32'(e.udf));
        chk("wr_ptr_range", 32'(wr_ptr < 8'(DEPTH)), 32'd1);
        chk("rd_ptr_range", 32'(rd_ptr < 8'(DEPTH)), 32'd1);
      end
    end
  end

  initial begin
    int pw;
    int pr;
    wr_total = 0;
    rd_total = 0;
    m_dout   = 8'h00;
    m_ovf    = 1'b0;
    m_udf    = 1'b0;

    // Reset state, then reset in the middle of a stream of writes.
    step(1'b0, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 8'($urandom));
    step(1'b0, 1'b1, 1'b0, 8'h99);
    step(1'b1, 1'b0, 1'b0, 8'h00);

    // Read on empty straight after reset.
    step(1'b1, 1'b0, 1'b1, 8'h00);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b0, 8'h00);

    // Fill with 0x00..0x0F, write on full, then drain.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b1, 1'b0, 8'(i));
    step(1'b1, 1'b1, 1'b0, 8'hAA);
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 1'b1, 8'h00);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b0, 8'h00);

    // Simultaneous write and read on a full FIFO, then drain.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b1, 1'b0, 8'(8'h30 + i));
    step(1'b1, 1'b1, 1'b1, 8'h55);
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 1'b1, 8'h00);

    // Simultaneous write and read on an empty FIFO: no fall-through.
    step(1'b1, 1'b1, 1'b1, 8'h77);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 1'b1, 8'h00);
    step(1'b1, 1'b0, 1'b0, 8'h00);

    // Random soak; the bias changes every 100 cycles to reach both ends.
    for (int i = 0; i < 1000; i++) begin
      if (i % 100 == 0) begin
        pw = $urandom_range(20, 80);
        pr = $urandom_range(20, 80);
      end
      step(1'b1, 1'($urandom_range(0, 99) < pw), 1'($urandom_range(0, 99) < pr),
           8'($urandom));
    end

    step(1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_fifo_core
`default_nettype wire

// File: doc/fifo_core.md
Name: fifo_core

Overview:
Synchronous single-clock FIFO buffer that produces the status and pointer signals consumed by the team's FIFO protocol checker: fifo_full, fifo_empty, wr_ptr, rd_ptr and cnt. It sits between a byte producer and a byte consumer. The checker binds directly to its ports with no glue logic.

Parameters:
DEPTH, 16, number of entries; power of two, 2..128.
WIDTH, 8, data word width in bits.

Ports:
clk  input  1  system clock; all state updates on its rising edge.
rst  input  1  asynchronous, active-low reset.
fifo_write  input  1  write request; data_in is captured when the write is accepted.
fifo_read  input  1  read request.
data_in  input  WIDTH  write data.
data_out  output  WIDTH  registered read data.
fifo_full  output  1  high when cnt == DEPTH.
fifo_empty  output  1  high when cnt == 0.
wr_ptr  output  8  next write slot, 0..DEPTH-1; upper bits always 0.
rd_ptr  output  8  next read slot, 0..DEPTH-1; upper bits always 0.
cnt  output  8  current occupancy, 0..DEPTH.
overflow  output  1  sticky; set when a write is rejected.
underflow  output  1  sticky; set when a read is rejected.

Behaviour:
- Reset (rst == 0, asynchronous, any cycle):
  - wr_ptr = 0, rd_ptr = 0, cnt = 0, data_out = 0.
  - fifo_empty = 1, fifo_full = 0, overflow = 0, underflow = 0.
  - Memory contents are not reset.
- Reset mid-operation aborts any transfer in flight. The first accepted write after reset release goes to slot 0.
- Flags fifo_full and fifo_empty are decoded combinationally from the cnt register, so they are valid in the same cycle as cnt.
- Write acceptance: wr_ok = fifo_write && (!fifo_full || fifo_read).
- Read acceptance: rd_ok = fifo_read && !fifo_empty.
- On wr_ok: mem[wr_ptr] <= data_in; wr_ptr <= (wr_ptr == DEPTH-1) ? 0 : wr_ptr + 1.
- On rd_ok: data_out <= mem[rd_ptr]; rd_ptr advances with the same wrap rule.
- Read latency is 1 cycle: data is on data_out at the edge after the accepted read. data_out holds its value when no read is accepted.
- cnt update: +1 if wr_ok && !rd_ok; -1 if rd_ok && !wr_ok; otherwise unchanged.
- Boundary cases:
  - Full, write, no read: write rejected; wr_ptr and cnt stable; overflow <= 1.
  - Full, write and read together: both accepted; cnt stays DEPTH; both pointers advance.
  - Empty, read, no write: read rejected; rd_ptr stable; data_out stable; underflow <= 1.
  - Empty, write and read together: only the write is accepted; cnt becomes 1. No fall-through (read-during-write bypass).
  - Pointer wrap: DEPTH-1 -> 0. Pointers never take values >= DEPTH.
- overflow and underflow clear only on reset.
- No combinational path from inputs to outputs.

Decomposition:
- Package fifo_pkg:
  - PTR_W = 8 (shared by pointers and cnt).
  - Pointer/count typedef logic [PTR_W-1:0].
  - Function next_ptr(ptr, depth) implementing the wrap rule.
- Sub-module fifo_mem:
  - DEPTH x WIDTH register array.
  - One synchronous write port and one synchronous registered read port.
  - No reset on the array.
- Pointer, count, flag and error-flag logic stay in fifo_core.
- The checker module is bound to fifo_core in the bench.

Test Plan (DEPTH=16, WIDTH=8):
1. Reset: drive rst = 0 mid-stream after 5 writes -> next cycle shows cnt = 0, wr_ptr = 0, rd_ptr = 0, fifo_empty = 1, fifo_full = 0, overflow = 0; checker reset_check passes.
2. Fill and drain: write 0x00..0x0F -> cnt = 16, fifo_full = 1, wr_ptr = 0 (wrapped). Then read 16 times -> data_out sequence 0x00..0x0F, each one cycle after its read; ends with cnt = 0, fifo_empty = 1, rd_ptr = 0.
3. Write on full: from full, assert fifo_write only with data_in = 0xAA -> wr_ptr stays 0, cnt stays 16, overflow = 1. Subsequent drain never returns 0xAA; checker write_full_assert passes.
4. Read on empty: from reset, assert fifo_read only -> rd_ptr stays 0, data_out stays 0x00, underflow = 1; checker read_empty_assert passes.
5. Simultaneous at the boundaries:
   - Full, write 0x55 and read together -> cnt stays 16, both pointers advance by 1; 0x55 emerges after the 15 older entries.
   - Empty, write and read together -> cnt = 1, rd_ptr = 0.
6. Wrap soak: 1000 cycles of random fifo_write/fifo_read checked against a reference queue model -> data order matches; cnt equals the model occupancy every cycle; pointers always < 16.
